// File: rtl/keycode_cmd_queue.sv
// ============================================================================
//  Module   : keycode_cmd_queue
//  Purpose  : Converts raw USB keycodes into direction commands, queues them,
//             and releases one per video frame on the vsync falling edge.
//             Optional key auto-repeat is enabled by defining KCQ_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keycode_cmd_queue #(
    parameter int DEPTH         = 4,
    parameter int REPEAT_FRAMES = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [7:0]               keycode,
    input  logic                     vs,
    input  logic                     ovf_clr,
    output logic [7:0]               cmd_out,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    generate
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("keycode_cmd_queue: DEPTH must be a power of 2 in 2..16");
        end
        if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_repeat
            $error("keycode_cmd_queue: REPEAT_FRAMES must be in 1..255");
        end
    endgenerate

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    kc_q;
    logic          vs_q;

    logic accepted;
    logic press;
    logic tick;
    logic full;
    logic empty;
    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;
    logic rpt_push;

    always_comb begin
        accepted = 1'b0;
        case (keycode)
            8'h1A, 8'h16, 8'h04, 8'h07: accepted = 1'b1;
            default:                    accepted = 1'b0;
        endcase
    end

    // Accepted codes are all nonzero, so a change to 0x00 can never press.
    assign press    = accepted && (keycode != kc_q);
    assign tick     = vs_q && !vs;
    assign full     = (fill == FW'(DEPTH));
    assign empty    = (fill == '0);
    assign pop      = tick && !empty;
    assign push_req = press || rpt_push;
    // A pop on the same edge frees the slot the push needs.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

`ifdef KCQ_REPEAT_EN
    logic [7:0] rpt_cnt;
    logic       held;

    assign held     = accepted && (keycode == kc_q);
    assign rpt_push = tick && held && (rpt_cnt == 8'(REPEAT_FRAMES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rpt_cnt <= 8'h00;
        end else if (!held) begin
            rpt_cnt <= 8'h00;
        end else if (tick) begin
            rpt_cnt <= rpt_push ? 8'h00 : rpt_cnt + 8'h01;
        end
    end
`else
    assign rpt_push = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            kc_q      <= 8'h00;
            vs_q      <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            cmd_out   <= 8'h00;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            kc_q <= keycode;
            vs_q <= vs;

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (tick) begin
                if (pop) begin
                    cmd_out   <= mem[rd_ptr];
                    cmd_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                end else begin
                    cmd_out   <= 8'h00;
                    cmd_valid <= 1'b0;
                end
            end

            case ({push_ok, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= keycode;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keycode_cmd_queue.sv
// ============================================================================
//  Module   : tb_keycode_cmd_queue
//  Purpose  : Self-checking bench for keycode_cmd_queue (DEPTH=4, REPEAT_FRAMES=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keycode_cmd_queue;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       vs;
    logic       ovf_clr;
    logic [7:0] cmd_out;
    logic       cmd_valid;
    logic [2:0] fill;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    keycode_cmd_queue #(
        .DEPTH         (4),
        .REPEAT_FRAMES (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .vs        (vs),
        .ovf_clr   (ovf_clr),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid),
        .fill      (fill),
        .overflow  (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] kc;
        logic       v;
        logic       clr;
        logic [7:0] e_cmd;
        logic       e_val;
        logic [2:0] e_fill;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic [7:0] kc, input logic v, input logic clr,
                                input logic [7:0] e_cmd, input logic e_val,
                                input logic [2:0] e_fill, input logic e_ovf);
        vec_t r;
        r.kc = kc; r.v = v; r.clr = clr;
        r.e_cmd = e_cmd; r.e_val = e_val; r.e_fill = e_fill; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [7:0] e_cmd, input logic e_val,
                           input logic [2:0] e_fill, input logic e_ovf);
        chk({name, ".cmd_out"},   32'(cmd_out),   32'(e_cmd));
        chk({name, ".cmd_valid"}, 32'(cmd_valid), 32'(e_val));
        chk({name, ".fill"},      32'(fill),      32'(e_fill));
        chk({name, ".overflow"},  32'(overflow),  32'(e_ovf));
    endtask

    // Four presses in a row fill the queue with 1A,16,04,07.
    task automatic fill_four();
        keycode = 8'h1A; step();
        keycode = 8'h16; step();
        keycode = 8'h04; step();
        keycode = 8'h07; step();
    endtask

    initial begin
        int hits;
        int exp_hits;
        logic [7:0] drain_exp [4];

        // Single tap, then five taps overflowing DEPTH=4 and draining.
        vecs[0]  = mk(8'h1A, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        vecs[1]  = mk(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        vecs[2]  = mk(8'h00, 1'b0, 1'b0, 8'h1A, 1'b1, 3'd0, 1'b0);
        vecs[3]  = mk(8'h00, 1'b1, 1'b0, 8'h1A, 1'b1, 3'd0, 1'b0);
        vecs[4]  = mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        vecs[5]  = mk(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        vecs[6]  = mk(8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0);
        vecs[7]  = mk(8'h07, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 1'b0);
        vecs[8]  = mk(8'h16, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0);
        vecs[9]  = mk(8'h1A, 1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b0);
        vecs[10] = mk(8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1);
        vecs[11] = mk(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1);
        vecs[12] = mk(8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 3'd3, 1'b1);
        vecs[13] = mk(8'h00, 1'b1, 1'b0, 8'h04, 1'b1, 3'd3, 1'b1);
        vecs[14] = mk(8'h00, 1'b0, 1'b0, 8'h07, 1'b1, 3'd2, 1'b1);
        vecs[15] = mk(8'h00, 1'b1, 1'b0, 8'h07, 1'b1, 3'd2, 1'b1);
        vecs[16] = mk(8'h00, 1'b0, 1'b0, 8'h16, 1'b1, 3'd1, 1'b1);
        vecs[17] = mk(8'h00, 1'b1, 1'b0, 8'h16, 1'b1, 3'd1, 1'b1);
        vecs[18] = mk(8'h00, 1'b0, 1'b0, 8'h1A, 1'b1, 3'd0, 1'b1);
        vecs[19] = mk(8'h00, 1'b1, 1'b0, 8'h1A, 1'b1, 3'd0, 1'b1);
        vecs[20] = mk(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        vecs[21] = mk(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        vecs[22] = mk(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        Reset = 1'b1; keycode = 8'h00; vs = 1'b1; ovf_clr = 1'b0;
        step(); step(); step();
        chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        Reset = 1'b0;

        // Idle frames after reset emit nothing.
        for (int f = 0; f < 2; f++) begin
            vs = 1'b0; step();
            chk_all("idle_tick", 8'h00, 1'b0, 3'd0, 1'b0);
            vs = 1'b1; step(); step();
        end

        for (int i = 0; i < 23; i++) begin
            keycode = vecs[i].kc; vs = vecs[i].v; ovf_clr = vecs[i].clr;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_val,
                    vecs[i].e_fill, vecs[i].e_ovf);
        end
        ovf_clr = 1'b0;

        // Full queue, press coincides with tick: pop and push both happen.
        fill_four();
        chk("full.fill", 32'(fill), 32'd4);
        keycode = 8'h16; vs = 1'b0; step();
        chk_all("push_pop_full", 8'h1A, 1'b1, 3'd4, 1'b0);
        keycode = 8'h00; vs = 1'b1; step();
        drain_exp[0] = 8'h16; drain_exp[1] = 8'h04; drain_exp[2] = 8'h07; drain_exp[3] = 8'h16;
        for (int k = 0; k < 4; k++) begin
            vs = 1'b0; step();
            chk($sformatf("drain%0d.cmd_out", k), 32'(cmd_out), 32'(drain_exp[k]));
            chk($sformatf("drain%0d.fill", k), 32'(fill), 32'(3 - k));
            vs = 1'b1; step();
        end

        // Dropped push and ovf_clr on the same edge: set wins.
        fill_four();
        keycode = 8'h1A; ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        chk("set_wins.overflow", 32'(overflow), 32'd1);
        chk("set_wins.fill", 32'(fill), 32'd4);
        keycode = 8'h00; step();
        vs = 1'b0; step();
        chk_all("pre_reset_tick", 8'h1A, 1'b1, 3'd3, 1'b1);
        vs = 1'b1; keycode = 8'h07; step();
        chk("pre_reset.fill", 32'(fill), 32'd4);

        // Mid-frame asynchronous reset.
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk_all("async_reset", 8'h00, 1'b0, 3'd0, 1'b0);
        keycode = 8'h00;
        step(); step();
        Reset = 1'b0;
        step();
        vs = 1'b0; step();
        chk_all("post_reset_tick", 8'h00, 1'b0, 3'd0, 1'b0);
        vs = 1'b1; step();

        // Hold 0x16 for 20 frames.
`ifdef KCQ_REPEAT_EN
        exp_hits = 3;
`else
        exp_hits = 1;
`endif
        hits = 0;
        keycode = 8'h16; step();
        for (int f = 0; f < 20; f++) begin
            vs = 1'b0; step();
            if (cmd_valid === 1'b1 && cmd_out === 8'h16) hits++;
            vs = 1'b1; step(); step(); step();
        end
        chk("hold20.frames_with_cmd", 32'(hits), 32'(exp_hits));
        chk("hold20.fill", 32'(fill), 32'd0);
        chk("hold20.overflow", 32'(overflow), 32'd0);
        keycode = 8'h00; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
